// File: rtl/qei_decoder_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : qei_decoder_param
//  Purpose  : Quadrature encoder interface. Synchronises and glitch-filters
//             A/B/Z, decodes x4/x2/x1 steps into a wrapping position counter,
//             and provides index clear, preset load and a sticky error flag.
//  Revision : 1.0  initial release
// ============================================================================
module qei_decoder_param #(
  parameter int CNT_W       = 16,
  parameter int FILT_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              a_in,
  input  logic              b_in,
  input  logic              z_in,
  input  logic [1:0]        mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              idx_clr_en,
  input  logic              preset_load,
  input  logic [CNT_W-1:0]  preset_val,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  count,
  output logic              dir,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic              idx_pulse,
  output logic              err
);

  localparam logic [CNT_W-1:0] C_ALL_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  // Bit order used throughout the front end: [2]=A, [1]=B, [0]=Z
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]                  w_sync;
  logic [2:0]                  w_filt;
  logic [1:0]                  w_cur_s;
  logic [1:0]                  r_prev_s;
  logic                        r_prev_z;
  logic                        w_z_rise;
  logic                        w_fwd;
  logic                        w_rev;
  logic                        w_illegal;
  logic                        w_a_chg;
  logic                        w_up;
  logic                        w_dn;

  // Metastability synchroniser: shift raw inputs through SYNC_STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {a_in, b_in, z_in}};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // One run-length glitch filter per input; output follows the synchronised
  // value only after filt_len+1 consecutive cycles of disagreement
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      logic [FILT_W-1:0] r_run;
      logic              r_bit;

      // Count disagreeing cycles; any agreement restarts the run
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_run <= '0;
          r_bit <= 1'b0;
        end else if (w_sync[gi] != r_bit) begin
          // >= keeps a shortened filt_len from stranding a longer run
          if (r_run >= filt_len) begin
            r_bit <= w_sync[gi];
            r_run <= '0;
          end else begin
            r_run <= r_run + FILT_W'(1);
          end
        end else begin
          r_run <= '0;
        end
      end

      assign w_filt[gi] = r_bit;
    end
  endgenerate

  assign w_cur_s  = w_filt[2:1];
  assign w_z_rise = w_filt[0] & ~r_prev_z;

  // Previous filtered state, tracked every cycle even while counting is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_s <= 2'b00;
      r_prev_z <= 1'b0;
    end else begin
      r_prev_s <= w_cur_s;
      r_prev_z <= w_filt[0];
    end
  end

  // Classify the prev->cur transition and gate it by the decode mode
  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    w_up  = 1'b0;
    w_dn  = 1'b0;
    case ({r_prev_s, w_cur_s})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_rev = 1'b1;
      default: ;
    endcase
    case (mode)
      2'b01: begin
        w_up = w_fwd & w_a_chg;
        w_dn = w_rev & w_a_chg;
      end
      2'b10: begin
        w_up = ({r_prev_s, w_cur_s} == 4'b10_00);
        w_dn = ({r_prev_s, w_cur_s} == 4'b00_10);
      end
      default: begin
        w_up = w_fwd;
        w_dn = w_rev;
      end
    endcase
  end

  assign w_a_chg   = r_prev_s[1] ^ w_cur_s[1];
  assign w_illegal = ((r_prev_s ^ w_cur_s) == 2'b11);

  // Position counter with preset > index clear > step priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      idx_pulse  <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      idx_pulse  <= w_z_rise;
      if (preset_load) begin
        count <= preset_val;
      end else if (w_z_rise && idx_clr_en) begin
        // Index clear discards any coincident step entirely
        count <= '0;
      end else if (ena && w_up) begin
        count      <= count + C_ONE;
        dir        <= 1'b1;
        step_pulse <= 1'b1;
        wrap_pulse <= (count == C_ALL_ONES);
      end else if (ena && w_dn) begin
        count      <= count - C_ONE;
        dir        <= 1'b0;
        step_pulse <= 1'b1;
        wrap_pulse <= (count == '0);
      end
    end
  end

  // Sticky illegal-transition flag; a new error wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (w_illegal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qei_decoder_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_qei_decoder_param
//  Purpose  : Self-checking bench for qei_decoder_param with a position-based
//             reference model and randomized step sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qei_decoder_param;

  localparam int CNT_W       = 16;
  localparam int FILT_W      = 3;
  localparam int SYNC_STAGES = 2;
  localparam int MODN        = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              a_in = 1'b0;
  logic              b_in = 1'b0;
  logic              z_in = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [FILT_W-1:0] filt_len = '0;
  logic              idx_clr_en = 1'b0;
  logic              preset_load = 1'b0;
  logic [CNT_W-1:0]  preset_val = '0;
  logic              err_clr = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              dir;
  logic              step_pulse;
  logic              wrap_pulse;
  logic              idx_pulse;
  logic              err;

  qei_decoder_param #(
    .CNT_W(CNT_W), .FILT_W(FILT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .a_in(a_in), .b_in(b_in), .z_in(z_in),
    .mode(mode), .filt_len(filt_len),
    .idx_clr_en(idx_clr_en), .preset_load(preset_load), .preset_val(preset_val),
    .err_clr(err_clr),
    .count(count), .dir(dir), .step_pulse(step_pulse), .wrap_pulse(wrap_pulse),
    .idx_pulse(idx_pulse), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_step = 0;
  int n_wrap = 0;

  // Reference model: position modulo 2^CNT_W plus last direction, error, state
  int         m_count = 0;
  logic       m_dir = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_s = 2'b00;

  // Gray positions around the forward cycle 00,01,11,10
  logic [1:0] pos2s [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  // Pulse tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (step_pulse === 1'b1) n_step++;
      if (wrap_pulse === 1'b1) n_wrap++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int pos_of(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Signed step the decoder should apply for p->c in decode mode md
  function automatic int model_delta(input logic [1:0] p, input logic [1:0] c,
                                     input logic [1:0] md);
    int   d;
    logic fwd;
    if (p == c) return 0;
    d = (pos_of(c) - pos_of(p) + 4) % 4;
    if (d == 2) return 0;
    fwd = (d == 1);
    case (md)
      2'b01: return (p[1] != c[1]) ? (fwd ? 1 : -1) : 0;
      2'b10: begin
        if (p == 2'b10 && c == 2'b00) return 1;
        if (p == 2'b00 && c == 2'b10) return -1;
        return 0;
      end
      default: return fwd ? 1 : -1;
    endcase
  endfunction

  // Apply a new A/B level, advance the model, then hold for 'hold' cycles
  task automatic step_to(input logic [1:0] s, input int hold);
    int d;
    if ((s ^ m_s) == 2'b11) begin
      m_err = 1'b1;
    end else if (ena) begin
      d = model_delta(m_s, s, mode);
      if (d != 0) begin
        m_dir   = (d > 0);
        m_count = (m_count + d + MODN) % MODN;
      end
    end
    m_s  = s;
    a_in = s[1];
    b_in = s[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({count, dir, step_pulse, wrap_pulse, idx_pulse, err} !== '0) begin
      fails++;
      $display("FAIL reset_state: count=%0h dir=%b step=%b wrap=%b idx=%b err=%b, need all 0",
               count, dir, step_pulse, wrap_pulse, idx_pulse, err);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_x4_cycle();
    mode     = 2'b00;
    filt_len = '0;
    n_step   = 0;
    for (int k = 0; k < 4; k++) begin
      step_to(fwd_seq[k], 8);
      tests++;
      if (count !== CNT_W'(k + 1)) begin
        fails++;
        $display("FAIL x4_fwd_step%0d: count=%0d need %0d", k, count, k + 1);
      end
    end
    #1;
    tests++;
    if (n_step != 4 || dir !== 1'b1) begin
      fails++;
      $display("FAIL x4_fwd_pulses: steps=%0d dir=%b need 4 and 1", n_step, dir);
    end
    for (int k = 0; k < 4; k++) step_to(rev_seq[k], 8);
    tests++;
    if (count !== '0 || dir !== 1'b0) begin
      fails++;
      $display("FAIL x4_rev_cycle: count=%0d dir=%b need 0 and 0", count, dir);
    end
  endtask

  task automatic test_x2_x1();
    mode = 2'b01;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++) step_to(fwd_seq[k], 6);
    tests++;
    if (count !== CNT_W'(16)) begin
      fails++;
      $display("FAIL x2_8cycles: count=%0d need 16", count);
    end
    mode = 2'b10;
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++) step_to(fwd_seq[k], 6);
    tests++;
    if (count !== CNT_W'(24)) begin
      fails++;
      $display("FAIL x1_8cycles: count=%0d need 24", count);
    end
  endtask

  task automatic test_wrap();
    mode        = 2'b00;
    preset_val  = 16'hFFFF;
    preset_load = 1'b1;
    @(negedge clk);
    preset_load = 1'b0;
    m_count     = MODN - 1;
    tests++;
    if (count !== 16'hFFFF) begin
      fails++;
      $display("FAIL preset_ffff: count=%0h need ffff", count);
    end
    n_wrap = 0;
    step_to(2'b01, 8);
    #1;
    tests++;
    if (count !== '0 || n_wrap != 1) begin
      fails++;
      $display("FAIL wrap_fwd: count=%0h wraps=%0d need 0 and 1", count, n_wrap);
    end
  endtask

  task automatic test_filter();
    int old;
    filt_len = 3'd3;
    repeat (2) @(negedge clk);
    old  = m_count;
    a_in = ~m_s[1];
    repeat (2) @(negedge clk);
    a_in = m_s[1];
    repeat (12) @(negedge clk);
    tests++;
    if (count !== CNT_W'(old)) begin
      fails++;
      $display("FAIL filter_glitch: count=%0d need %0d", count, old);
    end
    step_to(2'b11, SYNC_STAGES + 4);
    tests++;
    if (count !== CNT_W'(old)) begin
      fails++;
      $display("FAIL filter_early: count=%0d need %0d", count, old);
    end
    @(negedge clk);
    tests++;
    if (count !== CNT_W'(m_count)) begin
      fails++;
      $display("FAIL filter_latency: count=%0d need %0d", count, m_count);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal();
    filt_len = '0;
    repeat (2) @(negedge clk);
    step_to(2'b00, 8);
    tests++;
    if (count !== CNT_W'(m_count) || err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_jump: count=%0d err=%b need %0d and 1", count, err, m_count);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear1: err=%b need 0", err);
    end
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_s     = 2'b11;
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_set_wins: err=%b need 1", err);
    end
    repeat (4) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b0 || count !== CNT_W'(m_count)) begin
      fails++;
      $display("FAIL err_clear2: err=%b count=%0d need 0 and %0d", err, count, m_count);
    end
  endtask

  task automatic test_index_preset();
    preset_val  = 16'd100;
    preset_load = 1'b1;
    @(negedge clk);
    preset_load = 1'b0;
    m_count     = 100;
    tests++;
    if (count !== 16'd100) begin
      fails++;
      $display("FAIL preset_100: count=%0d need 100", count);
    end
    idx_clr_en = 1'b1;
    a_in = 1'b1;
    b_in = 1'b0;
    z_in = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    m_s     = 2'b10;
    m_count = 0;
    tests++;
    if (count !== '0 || idx_pulse !== 1'b1) begin
      fails++;
      $display("FAIL index_clear: count=%0d idx=%b need 0 and 1", count, idx_pulse);
    end
    @(negedge clk);
    tests++;
    if (idx_pulse !== 1'b0) begin
      fails++;
      $display("FAIL idx_one_cycle: idx=%b need 0", idx_pulse);
    end
    z_in = 1'b0;
    repeat (6) @(negedge clk);
    z_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    preset_val  = 16'd1234;
    preset_load = 1'b1;
    @(negedge clk);
    preset_load = 1'b0;
    m_count     = 1234;
    tests++;
    if (count !== 16'd1234 || idx_pulse !== 1'b1) begin
      fails++;
      $display("FAIL preset_over_index: count=%0d idx=%b need 1234 and 1", count, idx_pulse);
    end
    z_in = 1'b0;
    idx_clr_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_in = 1'b0;
    b_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({count, dir, step_pulse, wrap_pulse, idx_pulse, err} !== '0) begin
      fails++;
      $display("FAIL async_reset: count=%0d dir=%b step=%b wrap=%b idx=%b err=%b, need all 0",
               count, dir, step_pulse, wrap_pulse, idx_pulse, err);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    m_count = 0;
    m_dir   = 1'b0;
    m_err   = 1'b0;
    m_s     = 2'b00;
    repeat (8) @(negedge clk);
    tests++;
    if (count !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard: count=%0d err=%b need 0 and 0", count, err);
    end
    step_to(2'b01, 8);
    tests++;
    if (count !== 16'd1 || dir !== 1'b1) begin
      fails++;
      $display("FAIL first_after_reset: count=%0d dir=%b need 1 and 1", count, dir);
    end
  endtask

  task automatic test_ena();
    ena    = 1'b0;
    n_step = 0;
    step_to(2'b11, 8);
    step_to(2'b10, 8);
    step_to(2'b00, 8);
    step_to(2'b01, 8);
    #1;
    tests++;
    if (count !== 16'd1 || err !== 1'b0 || n_step != 0) begin
      fails++;
      $display("FAIL ena_freeze: count=%0d err=%b steps=%0d need 1, 0, 0", count, err, n_step);
    end
    ena = 1'b1;
    step_to(2'b11, 8);
    tests++;
    if (count !== 16'd2) begin
      fails++;
      $display("FAIL ena_resume: count=%0d need 2", count);
    end
  endtask

  task automatic test_random();
    int         r;
    int         p;
    logic [1:0] s;
    for (int it = 0; it < 150; it++) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        filt_len = FILT_W'($urandom_range(0, 3));
        repeat (2) @(negedge clk);
      end
      ena = ($urandom_range(0, 7) != 0);
      r   = $urandom_range(0, 9);
      p   = pos_of(m_s);
      if (r == 0)      s = m_s ^ 2'b11;
      else if (r < 6)  s = pos2s[(p + 1) % 4];
      else             s = pos2s[(p + 3) % 4];
      step_to(s, int'(filt_len) + SYNC_STAGES + 4);
      tests++;
      if (count !== CNT_W'(m_count)) begin
        fails++;
        $display("FAIL rand_count it=%0d: count=%0d need %0d", it, count, m_count);
      end
      tests++;
      if (dir !== m_dir) begin
        fails++;
        $display("FAIL rand_dir it=%0d: dir=%b need %b", it, dir, m_dir);
      end
      tests++;
      if (err !== m_err) begin
        fails++;
        $display("FAIL rand_err it=%0d: err=%b need %b", it, err, m_err);
      end
      if (m_err && $urandom_range(0, 2) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
      end
    end
    ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_x4_cycle();
    test_x2_x1();
    test_wrap();
    test_filter();
    test_illegal();
    test_index_preset();
    test_reset_mid();
    test_ena();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qei_decoder_param.md
QEI_DECODER_PARAM -- requirements
Module: qei_decoder_param

Interface
REQ-001 SHALL have parameter CNT_W, default 16, position counter width (4..32).
REQ-002 SHALL have parameter FILT_W, default 3, width of runtime filter-length input.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  count enable
- a_in, b_in, z_in  in  1 each  raw encoder A/B/index, asynchronous
- mode  in  2  decode: 00 x4, 01 x2, 10 x1, 11 x4
- filt_len  in  FILT_W  glitch-filter length
- idx_clr_en  in  1  clear count on index
- preset_load  in  1  load preset_val into count
- preset_val  in  CNT_W  preset value
- err_clr  in  1  clear sticky error
- count  out  CNT_W  position
- dir  out  1  last counted direction, 1 = forward
- step_pulse  out  1  one-cycle pulse per counted step
- wrap_pulse  out  1  one-cycle pulse on counter wrap
- idx_pulse  out  1  one-cycle pulse on filtered Z rising edge
- err  out  1  sticky illegal-transition flag

Function
REQ-005 SHALL pass a_in, b_in, z_in each through SYNC_STAGES flip-flops before any other use.
REQ-006 SHALL update each filtered signal to its synchronised value only after the two have differed for filt_len+1 consecutive clocks; any cycle of agreement restarts the run.
REQ-007 SHALL define state S={A,B} from filtered signals; forward sequence 00->01->11->10->00; reverse is the opposite order.
REQ-008 SHALL register the previous S every clock, including when ena=0.
REQ-009 x4: SHALL count +1 on every forward and -1 on every reverse single-bit transition.
REQ-010 x2: SHALL count only transitions where A changes (00->10 and 11->01 reverse; 01->11 and 10->00 forward).
REQ-011 x1: SHALL count only 10->00 (+1) and 00->10 (-1).
REQ-012 SHALL treat a two-bit change of S as illegal: no count change, err set to 1.
REQ-013 SHALL update count, dir and step_pulse on the clock edge following the filtered-state change; edge-to-count latency SHALL be SYNC_STAGES+filt_len+2 clocks.
REQ-014 SHALL wrap count modulo 2^CNT_W; wrap_pulse=1 for one cycle on all-ones->0 forward or 0->all-ones reverse.
REQ-015 SHALL set dir only on a counted step; dir holds otherwise.
REQ-016 On a filtered Z rising edge, SHALL pulse idx_pulse for one cycle; if idx_clr_en=1, SHALL load count=0 that cycle, discarding any step.
REQ-017 Count-update priority SHALL be preset_load > index clear > step; preset_load SHALL also suppress step_pulse and wrap_pulse that cycle.
REQ-018 preset_load and index clear SHALL act regardless of ena.
REQ-019 ena=0 SHALL freeze count, dir, step_pulse=0, wrap_pulse=0; transitions during ena=0 SHALL be lost without error.
REQ-020 Illegal transitions SHALL set err regardless of ena.
REQ-021 err_clr SHALL clear err; set SHALL win over simultaneous clear.
REQ-022 Changes to mode or filt_len SHALL take effect on the next clock and SHALL not corrupt count.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear synchronisers, filters, previous state (to 00), filter run counters, count=0, dir=0, step_pulse=0, wrap_pulse=0, idx_pulse=0, err=0.
REQ-024 Reset asserted mid-sequence SHALL discard all in-flight transitions; after release, the first state change SHALL count only if it is a legal transition from 00.

Verification
REQ-025 x4, filt_len=0: one forward cycle 00,01,11,10,00, 8 clocks per step -> count +1 per step (4 total), dir=1, four step_pulses; reverse cycle -> count back to 0, dir=0.
REQ-026 x2 then x1: 8 forward cycles -> count +16 in x2; +8 in x1; wrap from preset 0xFFFF with one x4 forward step -> count=0, one wrap_pulse.
REQ-027 filt_len=3: 2-clock A glitch -> count unchanged; 5-clock-stable step -> +1 after SYNC_STAGES+5 clocks.
REQ-028 Jump 00->11 -> count unchanged, err=1; err_clr with simultaneous illegal jump -> err stays 1; err_clr alone -> err=0.
REQ-029 count=100, idx_clr_en=1, Z pulse coincident with a forward step -> count=0, idx_pulse=1; preset_load=1234 with simultaneous Z -> count=1234.
REQ-030 rst_n low for 1 clock mid-cycle -> all outputs 0 immediately; ena=0 during 4 forward steps -> count frozen, err=0.
